mem_responder: RTL and testbench

Synthesizable single-port memory responder that serves the multicycle RV32I core's memory interface. It accepts one read or one write request at a time on the core's `mem_read`/`mem_write` handshake and performs byte-masked writes into an internal word array. After a fixed, parameterized latency it returns a one-cycle `mem_resp` pulse, with read data for reads. It sits opposite the core in the MP3 testbench and FPGA top, replacing the behavioural magic memory.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory handshake between the multicycle core (master) and the memory responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: one request at a time, fixed latency, byte-masked
// writes, one-cycle mem_resp pulse with registered read data.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave mem
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [3:0]              be_reg;
  logic [31:0]             wdata_reg;
  logic                    wr_reg;
  logic                    rd_reg;
  logic                    resp_reg;
  logic                    busy_reg;
  logic                    rd_seen_reg;

  logic                    req;
  logic                    enter_resp;
  logic                    enter_ok;
  logic                    wr_en;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   op_idx;
  logic [3:0]              op_be;
  logic [31:0]             op_wdata;
  logic                    op_wr;
  logic                    op_rd;
  logic [31:0]             rd_word;
  logic                    unused_addr_bits;

  assign req              = mem.mem_read | mem.mem_write;
  assign unused_addr_bits = ^{mem.mem_address[31:ADDR_WIDTH+2], mem.mem_address[1:0]};

  // With LATENCY==1 the array access happens on the capture edge, so the live
  // inputs are used in IDLE and the captured copy everywhere else.
  always_comb begin
    op_idx     = idx_reg;
    op_be      = be_reg;
    op_wdata   = wdata_reg;
    op_wr      = wr_reg;
    op_rd      = rd_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        op_idx     = mem.mem_address[ADDR_WIDTH+1:2];
        op_be      = mem.mem_byte_enable;
        op_wdata   = mem.mem_wdata;
        op_wr      = mem.mem_write;
        op_rd      = mem.mem_read;
        enter_resp = req && (LATENCY == 1);
      end
      WAIT:    enter_resp = (cnt_reg == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  assign enter_ok = enter_resp & rst;
  assign wr_en    = enter_ok & op_wr;
  assign rd_en    = enter_ok & op_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      be_reg      <= 4'd0;
      wdata_reg   <= 32'h0;
      wr_reg      <= 1'b0;
      rd_reg      <= 1'b0;
      resp_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      rd_seen_reg <= 1'b0;
    end else begin
      resp_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            idx_reg   <= mem.mem_address[ADDR_WIDTH+1:2];
            be_reg    <= mem.mem_byte_enable;
            wdata_reg <= mem.mem_wdata;
            wr_reg    <= mem.mem_write;
            rd_reg    <= mem.mem_read;
            cnt_reg   <= CNT_INIT;
            busy_reg  <= 1'b1;
            if (LATENCY == 1) begin
              state_reg <= RESP;
              resp_reg  <= 1'b1;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
          end
        end
        RESP: begin
          // Core is still holding its request here; never re-accept it.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
      if (rd_en) begin
        rd_seen_reg <= 1'b1;
      end
    end
  end

  // One byte-wide array per lane keeps every lane a plain single-writer RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (wr_en && op_be[gi]) begin
          lane_mem[op_idx] <= op_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_lane_reg <= lane_mem[op_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

  // The raw read register has no reset; rd_seen_reg masks it to zero until the
  // first read after reset reloads it.
  assign mem.mem_rdata = rd_seen_reg ? rd_word : 32'h0;
  assign mem.mem_resp  = resp_reg;
  assign mem.busy      = busy_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 3 and 1); expected responses are queued
// at issue and checked by a monitor whenever mem_resp is seen.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int   lat [2] = '{3, 1};

  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] addr_r [2];
  logic [3:0]  be_r   [2];
  logic [31:0] wd_r   [2];
  logic        resp_w [2];
  logic        busy_w [2];
  logic [31:0] rdat_w [2];
  logic [31:0] last_rd [2];

  exp_t q0[$];
  exp_t q1[$];

  mem_responder_if if_a ();
  mem_responder_if if_b ();

  assign if_a.mem_read        = rd_r[0];
  assign if_a.mem_write       = wr_r[0];
  assign if_a.mem_address     = addr_r[0];
  assign if_a.mem_byte_enable = be_r[0];
  assign if_a.mem_wdata       = wd_r[0];
  assign if_b.mem_read        = rd_r[1];
  assign if_b.mem_write       = wr_r[1];
  assign if_b.mem_address     = addr_r[1];
  assign if_b.mem_byte_enable = be_r[1];
  assign if_b.mem_wdata       = wd_r[1];
  assign resp_w[0] = if_a.mem_resp;
  assign busy_w[0] = if_a.busy;
  assign rdat_w[0] = if_a.mem_rdata;
  assign resp_w[1] = if_b.mem_resp;
  assign busy_w[1] = if_b.busy;
  assign rdat_w[1] = if_b.mem_rdata;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut_a (.clk(clk), .rst(rst), .mem(if_a));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .mem(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Monitor: every mem_resp must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst && resp_w[d]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
          failures++;
          $display("FAIL unexpected_resp dut=%0d cycle=%0d", d, cyc);
        end else if (e.cyc != cyc || rdat_w[d] !== e.rdata) begin
          failures++;
          $display("FAIL resp dut=%0d actual cycle=%0d rdata=%h required cycle=%0d rdata=%h",
                   d, cyc, rdat_w[d], e.cyc, e.rdata);
        end else begin
          $display("resp dut=%0d cycle=%0d rdata=%h ok", d, cyc, rdat_w[d]);
        end
      end
    end
  end

  // Called #1 after a rising edge; holds the request until mem_resp like the core.
  task automatic do_req(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    check_val($sformatf("busy_at_issue_d%0d", d), {31'h0, busy_w[d]}, 32'h0);
    if (r) last_rd[d] = exp_rd;
    e.rdata = last_rd[d];
    e.cyc   = cyc + lat[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    rd_r[d] = r; wr_r[d] = w; addr_r[d] = a; be_r[d] = be; wd_r[d] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_w[d] && n < 40);
    if (!resp_w[d]) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout dut=%0d addr=%h actual=no_resp required=resp", d, a);
    end
    @(posedge clk);
    #1;
    rd_r[d] = 1'b0;
    wr_r[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_r[d] = 1'b0; wr_r[d] = 1'b0; addr_r[d] = 32'h0;
      be_r[d] = 4'h0; wd_r[d] = 32'h0; last_rd[d] = 32'h0;
    end
    @(negedge clk);
    check_val("reset_resp", {31'h0, resp_w[0]}, 32'h0);
    check_val("reset_busy", {31'h0, busy_w[0]}, 32'h0);
    check_val("reset_rdata", rdat_w[0], 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=3 responder
    do_req(0, 1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 1'b1, 32'h0000_0044, 4'hF, 32'h1122_3344, 32'h0);
    do_req(0, 1'b0, 1'b1, 32'h0000_0044, 4'b1000, 32'hAA00_0000, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'hAA22_3344);
    do_req(0, 1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h0000_BBCC, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'hAA22_BBCC);
    do_req(0, 1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h5A5A_5A5A, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h5A5A_5A5A);
    do_req(0, 1'b0, 1'b1, 32'h0000_0044, 4'b0000, 32'hFFFF_FFFF, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'hAA22_BBCC);
    // read+write together: written, and rdata returns the pre-write word
    do_req(0, 1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h1234_5678);
    do_req(0, 1'b0, 1'b1, 32'h0000_0048, 4'hF, 32'h0000_0000, 32'h0);

    // LATENCY=1 responder, back-to-back
    do_req(1, 1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, 32'h0);
    do_req(1, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'hCAFE_F00D);
    do_req(1, 1'b0, 1'b1, 32'h0000_000C, 4'hF, 32'h0102_0304, 32'h0);
    do_req(1, 1'b0, 1'b1, 32'h0000_000C, 4'b0100, 32'h00EE_0000, 32'h0);
    do_req(1, 1'b1, 1'b0, 32'h0000_000C, 4'h0, 32'h0, 32'h01EE_0304);

    // Reset in cycle 1 of a write to 0x48
    wr_r[0] = 1'b1; addr_r[0] = 32'h0000_0048; be_r[0] = 4'hF; wd_r[0] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check_val("busy_mid_write", {31'h0, busy_w[0]}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check_val("async_reset_resp", {31'h0, resp_w[0]}, 32'h0);
    check_val("async_reset_busy", {31'h0, busy_w[0]}, 32'h0);
    check_val("async_reset_rdata", rdat_w[0], 32'h0);
    wr_r[0] = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_reset_busy", {31'h0, busy_w[0]}, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0048, 4'h0, 32'h0, 32'h0000_0000);
    do_req(1, 1'b1, 1'b0, 32'h0000_000C, 4'h0, 32'h0, 32'h01EE_0304);

    repeat (3) @(posedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_expectations actual=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
